pc_fetch_sequencer: RTL
=======================

# pc_fetch_sequencer

Sequential fetch controller that owns the program counter and drives instruction fetch for the RISC-V core. It decodes the same 2-bit next-PC select used by the PC mux, resolves redirects from the execute stage, runs the req/ack handshake to instruction memory, and applies hazard stalls. It sits between instruction memory and the IF/ID pipeline register, replacing the free-running PC register plus mux pair.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the saturating redirect counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hazard-unit stall; holds the delivered instruction.
- br_valid  in  1  execute stage presents a resolved control-flow instruction this cycle.
- br_sel  in  2  00 PC+4, 01 PC+imm, 10 ALU result (jalr), 11 conditional branch.
- br_taken  in  1  branch condition result; used only when br_sel=11.
- br_pc_imm  in  32  PC+imm target from execute.
- br_alu  in  32  ALU target from execute; bit 0 forced to 0 before use.
- imem_ack  in  1  memory returns imem_rdata for the current request.
- imem_rdata  in  32  instruction word.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; equals pc.
- pc  out  32  current fetch PC.
- if_valid  out  1  if_instr/if_pc hold a valid instruction for IF/ID.
- if_instr  out  32  registered fetched instruction.
- if_pc  out  32  address of if_instr.
- flush  out  1  one-cycle pulse: kill IF/ID and ID/EX contents.
- misalign  out  1  sticky: redirect target had bits[1:0] != 0.
- redirect_cnt  out  CNT_W  saturating count of taken redirects.

## Operation
- States: BOOT, FETCH, HOLD, DRAIN, HALT.
- Reset (async): state=BOOT, pc=RESET_PC, all other outputs 0, redirect_cnt=0.
- BOOT: one cycle, imem_req=0, then FETCH.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack: if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+4 (mod 2^32, wraps FFFF_FFFC->0). If stall also high, go to HOLD instead; pc still advances. If no ack, if_valid<=0 unless stall is high (stall holds existing if_valid/if_instr).
- HOLD: imem_req=0; if_valid/if_instr/if_pc frozen while stall=1; on stall=0 return to FETCH.
- Redirect condition: br_valid & (br_sel=01 | br_sel=10 | (br_sel=11 & br_taken)). br_sel=00 or untaken 11 is no redirect.
- Target: 01 or 11 -> br_pc_imm; 10 -> {br_alu[31:1],1'b0}.
- On redirect in FETCH/HOLD/BOOT: flush=1 next cycle, if_valid<=0, pc<=target, redirect_cnt+1 (saturate at all-ones). If a request is outstanding in FETCH without ack this cycle, go to DRAIN; otherwise FETCH.
- DRAIN: imem_req=1, imem_addr=old pc held until ack; ack data discarded (if_valid stays 0); then FETCH at new pc (stored in pc register; imem_addr uses a separate drain address register).
- Priority: redirect > stall > sequential. Redirect overrides stall in the same cycle.
- Redirect with target[1:0] != 0: misalign<=1, if_valid<=0, flush pulse, state HALT. HALT: imem_req=0, pc frozen; only rst exits.
- br_valid in DRAIN or HALT ignored.

## Timing
- Zero-wait memory (ack in the req cycle): one instruction per cycle, if_valid continuous.
- Fetch latency: if_instr valid the cycle after imem_ack.
- First request: cycle 2 after rst deassert (BOOT occupies cycle 1).
- Redirect penalty: flush visible cycle after br_valid; first fetch at target same cycle as flush (FETCH) or after drain ack.
- imem_addr stable while imem_req=1 and no ack.
- rst mid-transaction: immediate return to reset values; pending ack ignored.

## Test plan
- Reset, RESET_PC=0, ack tied high -> imem_addr 0,4,8,C on consecutive cycles from cycle 2; if_pc lags by one cycle.
- stall high 3 cycles after fetch of 0x8 -> if_instr/if_pc=0x8 held 3 cycles, imem_req=0, resume at 0xC.
- br_valid, br_sel=11, br_taken=0 -> no flush, sequential; br_taken=1, br_pc_imm=0x40 -> flush pulse, next addr 0x40, redirect_cnt=1.
- br_sel=10, br_alu=0x101 while request outstanding with ack delayed 2 cycles -> DRAIN, old data dropped, then fetch 0x100.
- br_sel=01, br_pc_imm=0x42 -> misalign=1, HALT, imem_req=0 until rst.
- pc=FFFF_FFFC fetch -> next addr 0x0; redirect_cnt forced to saturate with CNT_W=2 -> stays 3.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the PC, runs the imem req/ack handshake, resolves execute-stage redirects and applies hazard stalls
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_valid,
  input  logic [1:0]       br_sel,
  input  logic             br_taken,
  input  logic [31:0]      br_pc_imm,
  input  logic [31:0]      br_alu,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  output logic [31:0]      pc,
  output logic             if_valid,
  output logic [31:0]      if_instr,
  output logic [31:0]      if_pc,
  output logic             flush,
  output logic             misalign,
  output logic [CNT_W-1:0] redirect_cnt
);
  typedef enum logic [2:0] {BOOT, FETCH, HOLD, DRAIN, HALT} state_t;
  state_t      state, state_n;
  logic [31:0] drain_addr, tgt;
  logic        redir, mis_tgt, pending;
  assign redir   = (state inside {BOOT, FETCH, HOLD}) & br_valid &
                   (br_sel == 2'b01 | br_sel == 2'b10 | (br_sel == 2'b11 & br_taken));
  assign tgt     = br_sel == 2'b10 ? {br_alu[31:1], 1'b0} : br_pc_imm;
  assign mis_tgt = |tgt[1:0];
  // a request left unanswered at redirect time must still be retired at its old address
  assign pending = state == FETCH & ~imem_ack;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= BOOT;
    else     state <= state_n;
  always_comb begin
    imem_req  = state == FETCH | state == DRAIN;
    imem_addr = state == DRAIN ? drain_addr : pc;
    state_n   = redir                                  ? (mis_tgt ? HALT : pending ? DRAIN : FETCH) :
                state == BOOT                          ? FETCH :
                (state == FETCH & imem_ack & stall)    ? HOLD  :
                (state == HOLD & ~stall)               ? FETCH :
                (state == DRAIN & imem_ack)            ? FETCH : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc           <= RESET_PC;
      drain_addr   <= '0;
      if_valid     <= 1'b0;
      if_instr     <= '0;
      if_pc        <= '0;
      flush        <= 1'b0;
      misalign     <= 1'b0;
      redirect_cnt <= '0;
    end else begin
      flush <= redir;
      if (redir) begin
        if_valid <= 1'b0;
        if (redirect_cnt != '1) redirect_cnt <= redirect_cnt + CNT_W'(1);
        if (mis_tgt) misalign <= 1'b1;
        else pc <= tgt;
        if (pending) drain_addr <= pc;
      end else if (state == FETCH) begin
        if (imem_ack) begin
          if_valid <= 1'b1;
          if_instr <= imem_rdata;
          if_pc    <= pc;
          pc       <= pc + 32'd4;
        end else if (!stall) if_valid <= 1'b0;
      end
    end
endmodule
